// File: rtl/rv_pkg.sv
// Shared board-level constants and types for the key conditioning path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

  // Core clock frequency of the board; the debounce window is derived from it.
  localparam int CORE_CLK_HZ = 50_000_000;

  // 10 ms of core clock: long enough to outlast mechanical contact bounce.
  localparam int KEY_DEBOUNCE_CYCLES = CORE_CLK_HZ / 100;

  // Per-key debounce states: two stable levels, each with a qualifying wait state.
  typedef enum logic [1:0] {
    ST_HIGH,
    WAIT_LOW,
    ST_LOW,
    WAIT_HIGH
  } key_db_state_t;

endpackage

// File: rtl/rv_key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM with qualify counter, press/release strobes.
// Latency: key_o and strobe change DEBOUNCE_CYCLES+2 edges after a settled raw input.
// Backpressure: none; strobes are one-cycle informational pulses and are never held.
module rv_key_debounce_ch
  import rv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic key_i,
  output logic key_o,
  output logic press_o,
  output logic release_o
);

  // Sized so DEBOUNCE_CYCLES itself fits; the count never exceeds DEBOUNCE_CYCLES-1.
  localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic          sync1_q;
  logic          sync2_q;
  key_db_state_t state_q;
  logic [CntW-1:0] cnt_q;
  logic          key_q;
  logic          press_q;
  logic          release_q;

  // Two-flop synchroniser; reset to the released level so no false press follows reset.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM: a new level must persist DEBOUNCE_CYCLES samples before it is accepted.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q   <= ST_HIGH;
      cnt_q     <= '0;
      key_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        ST_HIGH: begin
          if (!sync2_q) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CntOne;
          end
        end
        WAIT_LOW: begin
          if (sync2_q) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= ST_LOW;
            key_q   <= 1'b0;
            press_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        ST_LOW: begin
          if (sync2_q) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CntOne;
          end
        end
        WAIT_HIGH: begin
          if (!sync2_q) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q   <= ST_HIGH;
            key_q     <= 1'b1;
            release_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= ST_HIGH;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/rv_key_debounce.sv
// Board push-button conditioning: NUM_KEYS independent debounce channels.
// Latency: DEBOUNCE_CYCLES+2 edges from a settled raw key to key_o/strobe change.
// Backpressure: none; strobes are single-cycle and not held.
module rv_key_debounce
  import rv_pkg::*;
#(
  parameter int NUM_KEYS        = 1,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic [NUM_KEYS-1:0] key_i,
  output logic [NUM_KEYS-1:0] key_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o
);

  // Channels share nothing, so simultaneous transitions all report in the same cycle.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    rv_key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i    (clk_i),
      .arstn_i  (arstn_i),
      .key_i    (key_i[g]),
      .key_o    (key_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g])
    );
  end

endmodule

// File: tb/tb_rv_key_debounce.sv
// Self-checking bench for rv_key_debounce with NUM_KEYS=2, DEBOUNCE_CYCLES=4.
// Latency: checks outputs every cycle on the falling edge against a reference model.
// Backpressure: n/a.
module tb_rv_key_debounce;

  localparam int NK = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          arstn_i = 1'b0;
  logic [NK-1:0] key_i = '1;
  logic [NK-1:0] key_o;
  logic [NK-1:0] press_o;
  logic [NK-1:0] release_o;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: raw-key delay line, accepted level, strobes, sample history.
  typedef bit bq_t[$];
  bit [NK-1:0] m_p1, m_p2, m_lvl, m_press, m_rel;
  bq_t         m_hist[NK];

  // Scenario bookkeeping from observed outputs.
  int edge_n;
  int press_edge0, press_cnt0, rel_edge0, rel_cnt0, both_cnt;

  always #5 clk = ~clk;

  rv_key_debounce #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_i    (clk),
    .arstn_i  (arstn_i),
    .key_i    (key_i),
    .key_o    (key_o),
    .press_o  (press_o),
    .release_o(release_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model of one rising edge: a level is accepted once the last DC synchronised samples
  // (taken since reset / since the previous acceptance) all differ from the current level.
  task automatic model_edge(input bit rst_n, input bit [NK-1:0] keys);
    bit all_diff;
    if (!rst_n) begin
      m_p1 = '1; m_p2 = '1; m_lvl = '1; m_press = '0; m_rel = '0;
      for (int c = 0; c < NK; c++) m_hist[c].delete();
    end else begin
      for (int c = 0; c < NK; c++) begin
        m_press[c] = 1'b0;
        m_rel[c]   = 1'b0;
        m_hist[c].push_back(m_p2[c]);
        if (m_hist[c].size() > DC) void'(m_hist[c].pop_front());
        if (m_hist[c].size() == DC) begin
          all_diff = 1'b1;
          foreach (m_hist[c][i]) if (m_hist[c][i] == m_lvl[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[c] = ~m_lvl[c];
            if (m_lvl[c]) m_rel[c] = 1'b1;
            else          m_press[c] = 1'b1;
            m_hist[c].delete();
          end
        end
      end
      m_p2 = m_p1;
      m_p1 = keys;
    end
  endtask

  // One cycle: drive on the falling edge, model the rising edge, check on the next falling edge.
  task automatic step(input bit rst_n, input bit [NK-1:0] keys);
    arstn_i = rst_n;
    key_i   = keys;
    @(posedge clk);
    model_edge(rst_n, keys);
    @(negedge clk);
    edge_n++;
    if (press_o[0])   begin press_cnt0++; press_edge0 = edge_n; end
    if (release_o[0]) begin rel_cnt0++;   rel_edge0   = edge_n; end
    if (press_o == 2'b11) both_cnt++;
    chk("key_o", 32'(key_o), 32'(m_lvl));
    chk("press_o", 32'(press_o), 32'(m_press));
    chk("release_o", 32'(release_o), 32'(m_rel));
  endtask

  task automatic run(input bit rst_n, input bit [NK-1:0] keys, input int n);
    for (int i = 0; i < n; i++) step(rst_n, keys);
  endtask

  task automatic mark();
    edge_n = 0; press_edge0 = -1; press_cnt0 = 0; rel_edge0 = -1; rel_cnt0 = 0; both_cnt = 0;
  endtask

  initial begin
    bit [NK-1:0] rk;
    int hold;
    mark();

    // Reset state
    run(1'b0, 2'b11, 3);
    chk("rst_key", 32'(key_o), 32'h3);
    chk("rst_press", 32'(press_o), 32'h0);
    chk("rst_rel", 32'(release_o), 32'h0);

    // Clean press on key 0: accepted at edge 6
    mark();
    run(1'b1, 2'b10, 10);
    chk("clean_press_edge", 32'(press_edge0), 32'd6);
    chk("clean_press_cnt", 32'(press_cnt0), 32'd1);
    chk("clean_key1_idle", 32'(key_o[1]), 32'd1);

    // Release: accepted at edge 6, one cycle wide
    mark();
    run(1'b1, 2'b11, 10);
    chk("release_edge", 32'(rel_edge0), 32'd6);
    chk("release_cnt", 32'(rel_cnt0), 32'd1);

    // Glitch of 3 cycles rejected
    mark();
    run(1'b1, 2'b10, 3);
    run(1'b1, 2'b11, 10);
    chk("glitch3_press_cnt", 32'(press_cnt0), 32'd0);
    chk("glitch3_key", 32'(key_o[0]), 32'd1);

    // Low of 4 cycles accepted
    mark();
    run(1'b1, 2'b10, 4);
    run(1'b1, 2'b11, 12);
    chk("low4_press_cnt", 32'(press_cnt0), 32'd1);
    chk("low4_press_edge", 32'(press_edge0), 32'd6);

    // Bounce: low 2, high 1, then stable low from edge 4 -> press at edge 9
    mark();
    run(1'b1, 2'b10, 2);
    run(1'b1, 2'b11, 1);
    run(1'b1, 2'b10, 10);
    chk("bounce_press_cnt", 32'(press_cnt0), 32'd1);
    chk("bounce_press_edge", 32'(press_edge0), 32'd9);
    run(1'b1, 2'b11, 10);

    // Both keys pressed together -> one cycle with press_o == 2'b11
    mark();
    run(1'b1, 2'b00, 10);
    chk("simul_both", 32'(both_cnt), 32'd1);
    chk("simul_key", 32'(key_o), 32'h0);
    run(1'b1, 2'b11, 10);

    // Reset while key 0 is mid-qualification (WAIT_LOW, cnt=2 after edge 4)
    mark();
    run(1'b1, 2'b10, 4);
    step(1'b0, 2'b10);
    chk("midrst_key", 32'(key_o), 32'h3);
    chk("midrst_press", 32'(press_o), 32'h0);
    chk("midrst_rel", 32'(release_o), 32'h0);
    mark();
    run(1'b1, 2'b10, 10);
    chk("midrst_repress_edge", 32'(press_edge0), 32'd6);
    chk("midrst_repress_cnt", 32'(press_cnt0), 32'd1);
    run(1'b1, 2'b11, 10);

    // Randomised: per-key hold lengths around the debounce window, occasional reset
    rk = 2'b11;
    for (int i = 0; i < 1500; i++) begin
      hold = $urandom_range(1, 7);
      rk[$urandom_range(0, NK - 1)] ^= 1'b1;
      for (int j = 0; j < hold; j++) begin
        step(($urandom_range(0, 299) != 0), rk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
